// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI peripheral
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int SPI_MODE       = 0;
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - parallel transmit/receive handshake of the SPI peripheral
interface spi_peripheral_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage input synchronizer with rise/fall detect
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Flops come out of reset at the line's idle level so no edge is seen at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      dly_q  <= IDLE_LEVEL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - mode-0 SPI responder with holding register and multi-word frames
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SPI_SCLK,
  input  logic            SPI_CS,
  input  logic            SPI_MOSI,
  output logic            SPI_MISO,
  output logic            miso_oe,
  output logic            busy,
  output logic            tx_underrun,
  output logic            frame_abort,
  spi_peripheral_if.slave bus
);

  localparam int   CW   = $clog2(DATA_WIDTH + 1);
  localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(CPOL)) u_sclk_sync (
    .clk (clk), .rst_n (rst_n), .din (SPI_SCLK), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk (clk), .rst_n (rst_n), .din (SPI_CS), .rise (cs_rise), .fall (cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   abort_q, abort_d;
  logic                   load;
  logic [DATA_WIDTH-1:0]  rx_new;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    load        = 1'b0;
    rx_new      = {rx_shift_q, mosi_s};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        // CS rise wins over any SCLK edge detected in the same cycle.
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) abort_d = 1'b1;
        end else if (sclk_rise && bit_cnt_q != CNT_FULL) begin
          rx_shift_d = rx_new[DATA_WIDTH-2:0];
          bit_cnt_d  = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CNT_LAST) begin
            rx_data_d  = rx_new;
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == CNT_FULL) begin
            bit_cnt_d = '0;
            load      = 1'b1;
          end else if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end

    // Capture only when empty, so a same-cycle load has already taken the old contents.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign busy         = (state_q == ACTIVE);
  assign miso_oe      = busy;
  assign SPI_MISO     = busy & tx_shift_q[DATA_WIDTH-1];
  assign tx_underrun  = underrun_q;
  assign frame_abort  = abort_q;
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
